// File: rtl/avalon_wishbone_bridge.sv
// Avalon-MM slave to Wishbone classic master bridge: one Avalon transfer becomes one
// Wishbone cycle, abandoned after pTIMEOUT cycles without ack, with a saturating timeout count.
module avalon_wishbone_bridge #(
   parameter int unsigned        pDWIDTH  = 32,
   parameter int unsigned        pAWIDTH  = 10,
   parameter int unsigned        pTIMEOUT = 255,
   parameter logic [pDWIDTH-1:0] pERRDATA = '1
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic               i_Read,
   input  logic               i_Write,
   input  logic [pAWIDTH-1:0] iv_Address,
   input  logic [pDWIDTH-1:0] iv_WriteData,
   output logic               o_WaitReq,
   output logic [pDWIDTH-1:0] ov_ReadData,
   output logic               o_WbClk,
   output logic               o_WbCyc,
   output logic               o_WbStb,
   output logic               o_WbWnR,
   output logic [pAWIDTH-1:0] ov_WbAddress,
   output logic [pDWIDTH-1:0] ov_WbWriteData,
   output logic [3:0]         o4_WbByteEn,
   input  logic               i_WbAck,
   input  logic [pDWIDTH-1:0] iv_WbReadData,
   output logic               o_TimeoutPulse,
   output logic [15:0]        ov16_TimeoutCnt
);

   typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

   localparam logic [15:0] TermCnt = 16'(pTIMEOUT - 1);

   state_e state_q, state_d;

   logic               cyc_q, cyc_d;
   logic               wait_req_q, wait_req_d;
   logic               pulse_q, pulse_d;
   logic               wnr_q;
   logic [pAWIDTH-1:0] addr_q;
   logic [pDWIDTH-1:0] wdata_q;
   logic [pDWIDTH-1:0] rdata_q;
   logic [15:0]        tmo_cnt_q;
   logic [15:0]        bus_ctr_q;

   logic req;
   logic ack_ev;
   logic tmo_ev;

   assign req    = i_Read | i_Write;
   assign ack_ev = (state_q == StBus) & i_WbAck;
   // An ack on the terminal cycle beats the timeout.
   assign tmo_ev = (state_q == StBus) & ~i_WbAck & (bus_ctr_q == TermCnt);

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req) state_d = StBus;
         StBus:   if (ack_ev || tmo_ev) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Bus-facing controls are decoded from the next state so they come straight off flops.
   always_comb begin
      cyc_d      = (state_d == StBus);
      wait_req_d = (state_d != StDone);
      pulse_d    = tmo_ev;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         cyc_q      <= 1'b0;
         wait_req_q <= 1'b1;
         pulse_q    <= 1'b0;
         wnr_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         tmo_cnt_q  <= '0;
         bus_ctr_q  <= '0;
      end else begin
         cyc_q      <= cyc_d;
         wait_req_q <= wait_req_d;
         pulse_q    <= pulse_d;
         if (state_q == StIdle && req) begin
            wnr_q   <= i_Write;
            addr_q  <= iv_Address;
            wdata_q <= iv_WriteData;
         end
         if (state_q == StBus) begin
            bus_ctr_q <= bus_ctr_q + 16'd1;
         end else begin
            bus_ctr_q <= '0;
         end
         if (ack_ev && !wnr_q) begin
            rdata_q <= iv_WbReadData;
         end else if (tmo_ev && !wnr_q) begin
            rdata_q <= pERRDATA;
         end
         if (tmo_ev && tmo_cnt_q != 16'hFFFF) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
         end
      end
   end

   assign o_WbClk         = i_Clk;
   assign o_WaitReq       = wait_req_q;
   assign ov_ReadData     = rdata_q;
   assign o_WbCyc         = cyc_q;
   assign o_WbStb         = cyc_q;
   assign o_WbWnR         = wnr_q;
   assign ov_WbAddress    = addr_q;
   assign ov_WbWriteData  = wdata_q;
   assign o4_WbByteEn     = 4'hF;
   assign o_TimeoutPulse  = pulse_q;
   assign ov16_TimeoutCnt = tmo_cnt_q;

endmodule

// File: tb/tb_avalon_wishbone_bridge.sv
// Bench for avalon_wishbone_bridge: directed vector table, hand-written reset/stray-ack
// sequences, then random transfers checked against a transaction-level model.
module tb_avalon_wishbone_bridge;

   localparam int T = 8;

   logic        i_Clk = 1'b0;
   logic        i_Rst;
   logic        i_Read;
   logic        i_Write;
   logic [9:0]  iv_Address;
   logic [31:0] iv_WriteData;
   logic        o_WaitReq;
   logic [31:0] ov_ReadData;
   logic        o_WbClk;
   logic        o_WbCyc;
   logic        o_WbStb;
   logic        o_WbWnR;
   logic [9:0]  ov_WbAddress;
   logic [31:0] ov_WbWriteData;
   logic [3:0]  o4_WbByteEn;
   logic        i_WbAck;
   logic [31:0] iv_WbReadData;
   logic        o_TimeoutPulse;
   logic [15:0] ov16_TimeoutCnt;

   avalon_wishbone_bridge #(
      .pDWIDTH (32),
      .pAWIDTH (10),
      .pTIMEOUT(T)
   ) dut (
      .i_Clk          (i_Clk),
      .i_Rst          (i_Rst),
      .i_Read         (i_Read),
      .i_Write        (i_Write),
      .iv_Address     (iv_Address),
      .iv_WriteData   (iv_WriteData),
      .o_WaitReq      (o_WaitReq),
      .ov_ReadData    (ov_ReadData),
      .o_WbClk        (o_WbClk),
      .o_WbCyc        (o_WbCyc),
      .o_WbStb        (o_WbStb),
      .o_WbWnR        (o_WbWnR),
      .ov_WbAddress   (ov_WbAddress),
      .ov_WbWriteData (ov_WbWriteData),
      .o4_WbByteEn    (o4_WbByteEn),
      .i_WbAck        (i_WbAck),
      .iv_WbReadData  (iv_WbReadData),
      .o_TimeoutPulse (o_TimeoutPulse),
      .ov16_TimeoutCnt(ov16_TimeoutCnt)
   );

   always #5 i_Clk = ~i_Clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [9:0]  addr;
      logic [31:0] wdata;
      int          ack_at;     // BUS cycle carrying the ack, 0 = never
      logic [31:0] sdata;
      logic        exp_wnr;
      int          exp_cyc;
      logic [31:0] exp_rdata;
      int          exp_pulses;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with the request dropped.
   task automatic xfer(input vec_t v);
      int   bus    = 0;
      int   edges  = 0;
      int   pulses = 0;
      logic done   = 1'b0;
      i_Read       = v.rd;
      i_Write      = v.wr;
      iv_Address   = v.addr;
      iv_WriteData = v.wdata;
      i_WbAck      = 1'b0;
      while (!done && edges < 40) begin
         @(posedge i_Clk);
         edges++;
         @(negedge i_Clk);
         i_WbAck       = 1'b0;
         iv_WbReadData = $urandom;
         // The bridge must have latched these; scramble the Avalon side to prove it.
         iv_Address    = 10'($urandom);
         iv_WriteData  = $urandom;
         if (o_TimeoutPulse) pulses++;
         if (o_WbCyc) begin
            bus++;
            chk("wb_wnr", 32'(o_WbWnR), 32'(v.exp_wnr));
            chk("wb_addr", 32'(ov_WbAddress), 32'(v.addr));
            if (v.exp_wnr) chk("wb_wdata", ov_WbWriteData, v.wdata);
            chk("wb_stb", 32'(o_WbStb), 32'd1);
            chk("wb_byteen", 32'(o4_WbByteEn), 32'hF);
            if (bus == v.ack_at) begin
               i_WbAck       = 1'b1;
               iv_WbReadData = v.sdata;
            end
         end else if (!o_WaitReq) begin
            chk("read_data", ov_ReadData, v.exp_rdata);
            chk("timeout_cnt", 32'(ov16_TimeoutCnt), 32'(v.exp_cnt));
            @(posedge i_Clk);
            edges++;
            done = 1'b1;
            @(negedge i_Clk);
            i_Read  = 1'b0;
            i_Write = 1'b0;
            chk("waitreq_one_cycle", 32'(o_WaitReq), 32'd1);
            chk("pulse_one_cycle", 32'(o_TimeoutPulse), 32'd0);
            chk("read_data_stable", ov_ReadData, v.exp_rdata);
         end
      end
      i_Read  = 1'b0;
      i_Write = 1'b0;
      chk("completed_in_bound", 32'(done), 32'd1);
      chk("cyc_cycles", 32'(bus), 32'(v.exp_cyc));
      chk("latency", 32'(edges), 32'(v.exp_cyc + 2));
      chk("pulses", 32'(pulses), 32'(v.exp_pulses));
   endtask

   initial begin
      logic [31:0] m_rdata;
      logic [15:0] m_cnt;
      vec_t        v;

      vecs[0] = '{1'b0, 1'b1, 10'h012, 32'hA5A5_0001, 1, 32'h0,
                  1'b1, 1, 32'h0, 0, 16'd0};
      vecs[1] = '{1'b1, 1'b0, 10'h3FF, 32'h0, 5, 32'h1234_5678,
                  1'b0, 5, 32'h1234_5678, 0, 16'd0};
      vecs[2] = '{1'b1, 1'b0, 10'h055, 32'h0, 0, 32'h0,
                  1'b0, T, 32'hFFFF_FFFF, 1, 16'd1};
      vecs[3] = '{1'b1, 1'b0, 10'h100, 32'h0, 0, 32'h0,
                  1'b0, T, 32'hFFFF_FFFF, 1, 16'd2};
      vecs[4] = '{1'b1, 1'b0, 10'h0AA, 32'h0, T, 32'hCAFE_BABE,
                  1'b0, T, 32'hCAFE_BABE, 0, 16'd2};
      vecs[5] = '{1'b0, 1'b1, 10'h200, 32'hDEAD_BEEF, 0, 32'h0,
                  1'b1, T, 32'hCAFE_BABE, 1, 16'd3};
      vecs[6] = '{1'b1, 1'b1, 10'h0F0, 32'h1111_2222, 2, 32'h5555_AAAA,
                  1'b1, 2, 32'hCAFE_BABE, 0, 16'd3};

      i_Rst         = 1'b1;
      i_Read        = 1'b0;
      i_Write       = 1'b0;
      iv_Address    = '0;
      iv_WriteData  = '0;
      i_WbAck       = 1'b0;
      iv_WbReadData = '0;
      repeat (2) @(posedge i_Clk);
      @(negedge i_Clk);
      chk("rst_waitreq", 32'(o_WaitReq), 32'd1);
      chk("rst_cyc", 32'(o_WbCyc), 32'd0);
      chk("rst_stb", 32'(o_WbStb), 32'd0);
      chk("rst_wnr", 32'(o_WbWnR), 32'd0);
      chk("rst_addr", 32'(ov_WbAddress), 32'd0);
      chk("rst_wdata", ov_WbWriteData, 32'd0);
      chk("rst_rdata", ov_ReadData, 32'd0);
      chk("rst_pulse", 32'(o_TimeoutPulse), 32'd0);
      chk("rst_cnt", 32'(ov16_TimeoutCnt), 32'd0);
      chk("wb_clk", 32'(o_WbClk), 32'(i_Clk));
      i_Rst = 1'b0;
      @(negedge i_Clk);

      for (int i = 0; i < 7; i++) xfer(vecs[i]);

      // Stray ack while idle must be ignored.
      i_WbAck       = 1'b1;
      iv_WbReadData = 32'h0BAD_0BAD;
      for (int c = 0; c < 3; c++) begin
         @(posedge i_Clk);
         @(negedge i_Clk);
         chk("stray_ack_waitreq", 32'(o_WaitReq), 32'd1);
         chk("stray_ack_cyc", 32'(o_WbCyc), 32'd0);
      end
      i_WbAck = 1'b0;
      chk("stray_ack_rdata", ov_ReadData, 32'hCAFE_BABE);
      chk("stray_ack_cnt", 32'(ov16_TimeoutCnt), 32'd3);

      // Reset on the third BUS cycle of a read that is never acked.
      i_Read     = 1'b1;
      iv_Address = 10'h155;
      for (int c = 0; c < 3; c++) begin
         @(posedge i_Clk);
         @(negedge i_Clk);
      end
      chk("pre_reset_cyc", 32'(o_WbCyc), 32'd1);
      i_Rst = 1'b1;
      @(posedge i_Clk);
      @(negedge i_Clk);
      chk("mid_rst_cyc", 32'(o_WbCyc), 32'd0);
      chk("mid_rst_waitreq", 32'(o_WaitReq), 32'd1);
      chk("mid_rst_cnt", 32'(ov16_TimeoutCnt), 32'd0);
      chk("mid_rst_rdata", ov_ReadData, 32'd0);
      i_Rst  = 1'b0;
      i_Read = 1'b0;
      @(negedge i_Clk);
      v = '{1'b0, 1'b1, 10'h2C3, 32'h0F0F_1234, 3, 32'h0,
            1'b1, 3, 32'h0, 0, 16'd0};
      xfer(v);

      // Random transfers against a transaction-level model.
      m_rdata = 32'h0;
      m_cnt   = 16'd0;
      for (int n = 0; n < 40; n++) begin
         int op;
         op       = int'($urandom_range(0, 2));
         v.rd     = (op != 1);
         v.wr     = (op != 0);
         v.addr   = 10'($urandom);
         v.wdata  = $urandom;
         v.ack_at = int'($urandom_range(0, T + 2));
         v.sdata  = $urandom;
         v.exp_wnr = v.wr;
         if (v.ack_at >= 1 && v.ack_at <= T) begin
            v.exp_cyc    = v.ack_at;
            v.exp_pulses = 0;
            if (!v.wr) m_rdata = v.sdata;
         end else begin
            v.exp_cyc    = T;
            v.exp_pulses = 1;
            if (!v.wr) m_rdata = 32'hFFFF_FFFF;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
         v.exp_rdata = m_rdata;
         v.exp_cnt   = m_cnt;
         xfer(v);
         repeat ($urandom_range(0, 2)) @(negedge i_Clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
